// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: FSM encoding, constants and IF/ID bundle.
// Imported by the fetch stage, ID stage and hazard unit.
package if_stage_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr: NOP,
        pc4:   32'h0000_0000,
        valid: 1'b0
    };

    function automatic logic [31:0] align_pc(
        input logic [31:0] a
    );
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] sat_inc(
        input logic [31:0] c
    );
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with flush > load > hold priority.
// The same pattern is reused for the ID/EX register.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q <= IF_ID_BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection, BOOT/RUN/HALT
// control and the IF/ID register feeding decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        load;
    logic        flush;
    logic        halted;
    logic [31:0] fetch_count;
    if_id_t      fetch_d;
    if_id_t      fetch_q;

    assign pc_plus4 = pc + PC_INC;
    assign target   = align_pc(redirect_pc_i);

    assign fetch_d = '{
        instr: imem_instr_i,
        pc4:   pc_plus4,
        valid: 1'b1
    };

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        flush      = 1'b0;
        unique case (state)
            ST_BOOT: begin
                state_next = ST_RUN;
                pc_next    = RESET_PC;
                flush      = 1'b1;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    pc_next = target;
                    flush   = 1'b1;
                end else if (stall_i) begin
                    pc_next = pc;
                end else if (imem_instr_i == HALT_WORD) begin
                    state_next = ST_HALT;
                    flush      = 1'b1;
                end else begin
                    pc_next = pc_plus4;
                    load    = 1'b1;
                end
            end
            ST_HALT: begin
                // An older branch still in flight may pull us out of HALT.
                flush = 1'b1;
                if (redirect_i) begin
                    pc_next    = target;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_BOOT;
                pc_next    = RESET_PC;
                flush      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            halted      <= 1'b0;
            fetch_count <= 32'h0000_0000;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            halted <= (state_next == ST_HALT);
            if (load) begin
                fetch_count <= sat_inc(fetch_count);
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (load),
        .flush (flush),
        .d     (fetch_d),
        .q     (fetch_q)
    );

    assign imem_addr_o   = pc;
    assign if_id_instr_o = fetch_q.instr;
    assign if_id_pc4_o   = fetch_q.pc4;
    assign if_id_valid_o = fetch_q.valid;
    assign halted_o      = halted;
    assign fetch_count_o = fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, mid-run reset sequence and
// randomized run against a behavioural fetch model.
module tb_if_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] KEY  = 32'h1357_2468;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        halted;
    logic [31:0] cnt;
    logic        halt_en = 1'b0;
    logic [31:0] halt_addr = 32'h10;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a,
                                         input logic he,
                                         input logic [31:0] ha);
        return (he && a == ha) ? HALT : (a ^ KEY);
    endfunction

    assign instr = word(addr, halt_en, halt_addr);

    if_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_addr_o   (addr),
        .imem_instr_i  (instr),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .if_id_instr_o (id_instr),
        .if_id_pc4_o   (id_pc4),
        .if_id_valid_o (id_valid),
        .halted_o      (halted),
        .fetch_count_o (cnt)
    );

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic r,
                                input logic [31:0] t, input logic [31:0] a,
                                input logic [31:0] p4, input logic v,
                                input logic h, input logic [31:0] c);
        vec_t x;
        x.stall  = s;
        x.redir  = r;
        x.rpc    = t;
        x.addr   = a;
        x.pc4    = p4;
        x.instr  = v ? ((p4 - 32'd4) ^ KEY) : 32'h0;
        x.valid  = v;
        x.halted = h;
        x.cnt    = c;
        return x;
    endfunction

    // behavioural model of the fetch stage
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_boot, m_halt, m_valid;

    task automatic m_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
        m_boot = 1'b1; m_halt = 1'b0; m_valid = 1'b0;
    endtask

    task automatic m_bubble();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic m_step(input logic s, input logic r,
                          input logic [31:0] t, input logic [31:0] w);
        if (m_boot) begin
            m_boot = 1'b0;
            m_bubble();
        end else if (r) begin
            m_pc = t & 32'hFFFF_FFFC;
            m_halt = 1'b0;
            m_bubble();
        end else if (m_halt) begin
            m_bubble();
        end else if (s) begin
            // nothing moves
        end else if (w == HALT) begin
            m_halt = 1'b1;
            m_bubble();
        end else begin
            m_instr = w;
            m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        tbl.push_back(mk(0, 0, 32'h0, 32'h00, 32'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 32'h04, 32'h04, 1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0, 32'h08, 32'h08, 1, 0, 2));
        tbl.push_back(mk(1, 0, 32'h0, 32'h08, 32'h08, 1, 0, 2));
        tbl.push_back(mk(1, 0, 32'h0, 32'h08, 32'h08, 1, 0, 2));
        tbl.push_back(mk(0, 0, 32'h0, 32'h0C, 32'h0C, 1, 0, 3));
        tbl.push_back(mk(0, 0, 32'h0, 32'h10, 32'h10, 1, 0, 4));
        tbl.push_back(mk(0, 0, 32'h0, 32'h10, 32'h00, 0, 1, 4));
        tbl.push_back(mk(0, 0, 32'h0, 32'h10, 32'h00, 0, 1, 4));
        tbl.push_back(mk(1, 0, 32'h0, 32'h10, 32'h00, 0, 1, 4));
        tbl.push_back(mk(0, 0, 32'h0, 32'h10, 32'h00, 0, 1, 4));
        tbl.push_back(mk(0, 0, 32'h0, 32'h10, 32'h00, 0, 1, 4));
        tbl.push_back(mk(0, 1, 32'h20, 32'h20, 32'h00, 0, 0, 4));
        tbl.push_back(mk(0, 0, 32'h0, 32'h24, 32'h24, 1, 0, 5));
        tbl.push_back(mk(1, 1, 32'h43, 32'h40, 32'h00, 0, 0, 5));
        tbl.push_back(mk(0, 0, 32'h0, 32'h44, 32'h44, 1, 0, 6));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 0, 0, 6));
        tbl.push_back(mk(0, 0, 32'h0, 32'h00, 32'h00, 1, 0, 7));
        tbl.push_back(mk(0, 0, 32'h0, 32'h04, 32'h04, 1, 0, 8));

        // reset state
        halt_en = 1'b1;
        halt_addr = 32'h10;
        #12;
        chk("rst_addr", addr, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_cnt", cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // directed table
        for (int i = 0; i < tbl.size(); i++) begin
            stall = tbl[i].stall;
            redir = tbl[i].redir;
            rpc = tbl[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_addr", i), addr, tbl[i].addr);
            chk($sformatf("t%0d_pc4", i), id_pc4, tbl[i].pc4);
            chk($sformatf("t%0d_instr", i), id_instr, tbl[i].instr);
            chk($sformatf("t%0d_valid", i), {31'h0, id_valid},
                {31'h0, tbl[i].valid});
            chk($sformatf("t%0d_halted", i), {31'h0, halted},
                {31'h0, tbl[i].halted});
            chk($sformatf("t%0d_cnt", i), cnt, tbl[i].cnt);
        end

        // mid-run reset at PC 0x24 with nine fetches done
        halt_en = 1'b0;
        do_reset();
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("mr_pre_addr", addr, 32'h24);
        chk("mr_pre_cnt", cnt, 32'd9);
        #1 rst = 1'b0;
        #1;
        chk("mr_addr", addr, 32'h0);
        chk("mr_pc4", id_pc4, 32'h0);
        chk("mr_instr", id_instr, 32'h0);
        chk("mr_valid", {31'h0, id_valid}, 32'h0);
        chk("mr_halted", {31'h0, halted}, 32'h0);
        chk("mr_cnt", cnt, 32'h0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_boot_addr", addr, 32'h0);
        chk("mr_boot_valid", {31'h0, id_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("mr_first_valid", {31'h0, id_valid}, 32'h1);
        chk("mr_first_pc4", id_pc4, 32'h4);
        chk("mr_first_instr", id_instr, 32'h0 ^ KEY);
        chk("mr_first_cnt", cnt, 32'd1);

        // randomized run against the model
        halt_en = 1'b1;
        halt_addr = 32'h30;
        do_reset();
        m_reset();
        #1;
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom % 4) == 0;
            redir = ($urandom % 8) == 0;
            if (($urandom % 6) == 0)
                rpc = 32'hFFFF_FFF0 | ($urandom % 16);
            else
                rpc = $urandom % 256;
            chk("rnd_addr", addr, m_pc);
            m_step(stall, redir, rpc, word(m_pc, halt_en, halt_addr));
            @(posedge clk);
            #1;
            chk("rnd_pc4", id_pc4, m_pc4);
            chk("rnd_instr", id_instr, m_instr);
            chk("rnd_valid", {31'h0, id_valid}, {31'h0, m_valid});
            chk("rnd_halted", {31'h0, halted}, {31'h0, m_halt});
            chk("rnd_cnt", cnt, m_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, meaning the instruction encoding that stops fetch.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_addr_o, output, 32, the byte address to instruction memory; equals the current PC.
REQ-006 SHALL have port imem_instr_i, input, 32, the instruction word, combinational from memory in the same cycle.
REQ-007 SHALL have port stall_i, input, 1, the hazard-unit request to hold PC and IF/ID.
REQ-008 SHALL have port redirect_i, input, 1, the branch/jump taken signal, resolved downstream.
REQ-009 SHALL have port redirect_pc_i, input, 32, the redirect target byte address.
REQ-010 SHALL have port if_id_instr_o, output, 32, the IF/ID latched instruction.
REQ-011 SHALL have port if_id_pc4_o, output, 32, the IF/ID latched PC+4.
REQ-012 SHALL have port if_id_valid_o, output, 1, asserted when the IF/ID entry is a real fetched instruction.
REQ-013 SHALL have port halted_o, output, 1, asserted while the FSM is in HALT.
REQ-014 SHALL have port fetch_count_o, output, 32, the count of instructions latched valid into IF/ID.

Function
REQ-015 SHALL implement FSM states BOOT, RUN and HALT.
REQ-016 SHALL leave BOOT for RUN unconditionally after one cycle; during BOOT, PC holds RESET_PC and IF/ID loads a bubble.
REQ-017 SHALL, in RUN, apply next-PC priority redirect_i > stall_i > PC+4.
REQ-018 SHALL, on redirect, set PC to {redirect_pc_i[31:2],2'b00}; misaligned low bits are forced to zero.
REQ-019 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 SHALL load IF/ID with instr=0, pc4=0 and valid=0 on redirect_i, in any state; redirect overrides stall.
REQ-021 SHALL hold IF/ID and PC unchanged on stall_i without redirect_i.
REQ-022 SHALL otherwise have IF/ID capture imem_instr_i and PC+4 with valid=1.
REQ-023 SHALL, in RUN without stall or redirect, when imem_instr_i==HALT_WORD: go to HALT, hold PC at the halt address, and load IF/ID with a bubble.
REQ-024 SHALL, in HALT, hold PC and keep IF/ID a bubble each cycle.
REQ-025 SHALL, on redirect_i in HALT, load the target and return to RUN, because an older branch in flight wins.
REQ-026 SHALL increment fetch_count_o exactly when IF/ID is loaded with valid=1, and saturate at 32'hFFFF_FFFF.
REQ-027 SHALL have a latency of 1 cycle from imem_addr_o to IF/ID output.
REQ-028 SHALL have all outputs driven from registers, except imem_addr_o, which equals the PC register.

Reset
REQ-029 SHALL, when rst_i is low, asynchronously set PC=RESET_PC, state=BOOT, IF/ID instr/pc4=0, valid=0, halted_o=0 and fetch_count_o=0.
REQ-030 SHALL, on reset asserted mid-operation, including in HALT or during a stall, discard all state; the first valid fetch after release is at RESET_PC, in the second rising edge after deassertion.
REQ-031 SHALL register reset deassertion only on clk_i edges; no combinational path from rst_i to imem_addr_o other than the PC register reset.

Structure
REQ-032 SHALL take the FSM state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), the NOP constant 32'h0 and the PC increment constant 4 from a shared pipeline package also used by the ID stage and the hazard unit.
REQ-033 SHALL use one natural sub-module, if_id_reg, the IF/ID pipeline register with load/hold/flush controls, reused pattern-wise for ID/EX.
REQ-034 SHALL keep the PC register, next-PC mux and FSM in if_stage itself.

Verification
REQ-035 SHALL verify sequential fetch: memory returns addr-based words, no stall/redirect -> imem_addr_o 0,4,8,12; if_id_pc4_o 4,8,12 one cycle later; fetch_count_o=3 after three valid loads.
REQ-036 SHALL verify stall: stall_i high 2 cycles at PC=8 -> imem_addr_o stays 8, IF/ID holds pc4=8, count unchanged; the cycle after release IF/ID pc4=12.
REQ-037 SHALL verify redirect over stall: stall_i=1, redirect_i=1, redirect_pc_i=32'h0000_0043 -> next PC=32'h40, IF/ID valid=0, instr=0.
REQ-038 SHALL verify halt and recovery: HALT_WORD at 32'h10 -> halted_o=1, PC stays 32'h10, valid=0 for 5 cycles; then redirect to 32'h20 -> halted_o=0, next fetch at 32'h20.
REQ-039 SHALL verify wrap: redirect to 32'hFFFF_FFFC, no stall -> next imem_addr_o=32'h0, if_id_pc4_o=32'h0.
REQ-040 SHALL verify mid-run reset: rst_i low for 3 ns in RUN at PC=32'h24 with fetch_count_o=9 -> all outputs zero immediately, imem_addr_o=RESET_PC; after release, BOOT then fetch resumes from RESET_PC.
